// File: rtl/fifo_unpacker.sv
// fifo_unpacker: pops wide words from a show-ahead FIFO and replays each one
// as 2^ratio_bits narrow beats, LSB first, on a valid/ready stream.
// The next word is popped on the same edge that retires the final beat, so
// back-to-back words stream without a bubble.
// Integrator note: out_ready reaches fifo_read_enable combinationally.
// reset_n is expected to be released synchronously to clk by the system.
module fifo_unpacker #(
    parameter  int out_width  = 8,
    parameter  int ratio_bits = 2,
    localparam int in_width   = out_width << ratio_bits
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 fifo_empty,
    input  logic [in_width-1:0]  fifo_read_data,
    output logic                 fifo_read_enable,
    input  logic                 flush,
    output logic                 out_valid,
    output logic [out_width-1:0] out_data,
    output logic                 out_last,
    input  logic                 out_ready
);

    localparam int BEATS = 1 << ratio_bits;
    // beat_idx keeps one bit even in pass-through mode; it then stays at zero.
    localparam int IDX_W = (ratio_bits > 0) ? ratio_bits : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [in_width-1:0] word_reg, word_nxt;
    logic [IDX_W-1:0]    beat_idx, beat_idx_nxt;
    logic                word_valid;
    logic                accept;
    logic                load;

    assign word_valid = (state == HOLD);
    assign out_valid  = word_valid;
    assign out_last   = word_valid && (beat_idx == LAST_IDX);
    assign accept     = out_valid && out_ready;
    // Gating with reset_n keeps the pop request low for the whole reset,
    // even though IDLE with a non-empty FIFO would otherwise request a load.
    assign load = reset_n && !fifo_empty && !flush &&
                  (!word_valid || (accept && out_last));
    assign fifo_read_enable = load;

    generate
        if (ratio_bits == 0) begin : g_pass
            assign out_data = word_reg;
        end else begin : g_split
            logic [BEATS-1:0][out_width-1:0] word_beats;
            assign word_beats = word_reg;
            assign out_data   = word_beats[beat_idx];
        end
    endgenerate

    // Next state: flush beats load, load beats beat advance, retire to IDLE
    // only when the final beat goes and nothing is waiting in the FIFO.
    always_comb begin
        state_nxt    = state;
        word_nxt     = word_reg;
        beat_idx_nxt = beat_idx;
        if (flush) begin
            state_nxt    = IDLE;
            beat_idx_nxt = '0;
        end else if (load) begin
            state_nxt    = HOLD;
            word_nxt     = fifo_read_data;
            beat_idx_nxt = '0;
        end else if (accept && !out_last) begin
            beat_idx_nxt = beat_idx + 1'b1;
        end else if (accept && out_last) begin
            state_nxt    = IDLE;
            beat_idx_nxt = '0;
        end
    end

    // State, held word and beat pointer; all cleared by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            word_reg <= '0;
            beat_idx <= '0;
        end else begin
            state    <= state_nxt;
            word_reg <= word_nxt;
            beat_idx <= beat_idx_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_unpacker.sv
// tb_fifo_unpacker: drives fifo_unpacker from a queue-backed FIFO model and
// scores every beat against a queue of expected beats built from the words
// the model says should be popped.
module tb_fifo_unpacker;

    localparam int OW    = 8;
    localparam int RB    = 2;
    localparam int BEATS = 1 << RB;
    localparam int IW    = OW << RB;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [IW-1:0] fifo_read_data = '0;
    logic          fifo_read_enable;
    logic          flush = 1'b0;
    logic          out_valid;
    logic [OW-1:0] out_data;
    logic          out_last;
    logic          out_ready = 1'b0;

    typedef struct packed {
        logic [OW-1:0] data;
        logic          last;
    } beat_t;

    logic [IW-1:0] fifo_q[$];
    beat_t         exp_q[$];
    int            total = 0;
    int            bad = 0;
    bit            pop_pending = 1'b0;

    fifo_unpacker #(.out_width(OW), .ratio_bits(RB)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .fifo_empty       (fifo_empty),
        .fifo_read_data   (fifo_read_data),
        .fifo_read_enable (fifo_read_enable),
        .flush            (flush),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_last         (out_last),
        .out_ready        (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        fifo_empty     = (fifo_q.size() == 0);
        fifo_read_data = fifo_empty ? '0 : fifo_q[0];
    endtask

    task automatic push(input logic [IW-1:0] w);
        fifo_q.push_back(w);
        refresh();
    endtask

    // One clock: the FIFO model pops whatever the DUT requested at this edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (pop_pending && fifo_q.size() != 0) void'(fifo_q.pop_front());
        refresh();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until the given beat is on the output; a timeout is a failure.
    task automatic wait_beat(input logic [OW-1:0] b);
        int n;
        n = 0;
        while (!(out_valid && out_data == b) && n < 20) begin
            step();
            n++;
        end
        chk("wait_beat", out_data, b);
    endtask

    // Monitor: at each falling edge compare outputs with the expected beats,
    // then advance the reference model across the coming rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                chk("rst_valid", out_valid, 1'b0);
                chk("rst_data", out_data, '0);
                chk("rst_last", out_last, 1'b0);
                chk("rst_pop", fifo_read_enable, 1'b0);
                exp_q.delete();
                pop_pending = 1'b0;
            end else begin
                bit pred_pop;
                chk("valid", out_valid, exp_q.size() != 0);
                if (out_valid && exp_q.size() != 0) begin
                    chk("data", out_data, exp_q[0].data);
                    chk("last", out_last, exp_q[0].last);
                end
                if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
                // Flush drops whatever is left of the held word.
                if (flush) exp_q.delete();
                // A new word is taken only when the held one is finished.
                pred_pop = !flush && fifo_q.size() != 0 && exp_q.size() == 0;
                chk("pop", fifo_read_enable, pred_pop);
                if (pred_pop) begin
                    for (int b = 0; b < BEATS; b++) begin
                        beat_t nb;
                        nb.data = fifo_q[0][b*OW +: OW];
                        nb.last = (b == BEATS - 1);
                        exp_q.push_back(nb);
                    end
                end
                pop_pending = fifo_read_enable;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        // Reset with the FIFO empty.
        steps(3);
        reset_n = 1'b1;
        steps(2);

        // Single word, consumer always ready.
        out_ready = 1'b1;
        push(32'hDDCCBBAA);
        steps(7);

        // Two preloaded words stream back to back.
        push(32'h44332211);
        push(32'h88776655);
        steps(12);

        // Stall on BB for three cycles.
        push(32'hDDCCBBAA);
        wait_beat(8'hBB);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_data", out_data, 8'hBB);
            chk("stall_pop", fifo_read_enable, 1'b0);
        end
        out_ready = 1'b1;
        step();
        chk("resume", out_data, 8'hCC);
        steps(4);

        // Empty FIFO with ready high: nothing happens.
        steps(5);

        // Flush while on BB, then a fresh word.
        push(32'hDDCCBBAA);
        wait_beat(8'hBB);
        out_ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_valid", out_valid, 1'b0);
        out_ready = 1'b1;
        push(32'h0000EE01);
        step();
        chk("after_flush", out_data, 8'h01);
        steps(6);

        // Asynchronous reset mid-word on CC; the next head loads afterwards.
        push(32'hDDCCBBAA);
        push(32'h04030201);
        wait_beat(8'hCC);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst", out_valid, 1'b0);
        steps(2);
        reset_n = 1'b1;
        step();
        chk("reload", out_data, 8'h01);
        steps(6);

        // Random traffic with stalls and occasional flushes.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 4) push($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            step();
        end
        flush = 1'b0;
        out_ready = 1'b1;
        steps(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_unpacker.md
Name: fifo_unpacker

Overview:
- Downstream consumer of the synchronous FIFO.
- Pops wide words from the FIFO's show-ahead read port (read_data is valid combinationally whenever the FIFO is not empty).
- Splits each word into 2^ratio_bits narrow beats and presents them LSB-first on a valid/ready stream.
- Sits between a wide producer-side FIFO and narrow consumers (e.g. a byte-wide UART or bus master); no bubble between consecutive words.

Parameters:
- out_width, 8: beat width in bits.
- ratio_bits, 2: log2 of beats per FIFO word. 0 gives pass-through, 1 beat per word.
- in_width, out_width << ratio_bits: FIFO word width. Derived; not overridden.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset. Asserts immediately, releases synchronously to clk.
- fifo_empty  input  1  FIFO empty flag.
- fifo_read_data  input  in_width  FIFO head word. Valid when fifo_empty=0.
- fifo_read_enable  output  1  pops the FIFO head at the next clk edge.
- flush  input  1  synchronous discard of the held word.
- out_valid  output  1  beat available.
- out_data  output  out_width  current beat.
- out_last  output  1  current beat is the final beat of its word.
- out_ready  input  1  consumer accepts beat when out_valid && out_ready.

Behaviour:
- Registered state:
  - word_reg (in_width).
  - beat_idx (ratio_bits; 1-bit tie-off unused when ratio_bits=0).
  - word_valid (1).
- States:
  - IDLE: word_valid=0.
  - HOLD: word_valid=1.
- Reset (async, reset_n=0):
  - word_valid=0, beat_idx=0, word_reg=0.
  - out_valid=0, out_data=0, out_last=0, fifo_read_enable=0. These hold throughout reset.
- Combinational outputs:
  - out_valid = word_valid.
  - out_data = word_reg[beat_idx*out_width +: out_width].
  - out_last = word_valid && (beat_idx == 2^ratio_bits - 1).
  - accept = out_valid && out_ready.
  - load = !fifo_empty && !flush && (!word_valid || (accept && out_last)).
  - fifo_read_enable = load. It is never asserted when fifo_empty=1.
  - out_ready → fifo_read_enable is a combinational path. This is permitted and documented for the integrator.
- Transitions, evaluated each clk edge with priority top-down:
  - flush=1:
    - word_valid<=0, beat_idx<=0.
    - FIFO not popped that cycle.
    - A beat accepted in the same cycle counts as delivered, then the rest of the word is dropped.
  - load=1:
    - word_reg<=fifo_read_data, beat_idx<=0, word_valid<=1.
    - Covers IDLE→HOLD, and HOLD→HOLD on the final-beat handoff (zero-bubble).
  - accept && !out_last: beat_idx<=beat_idx+1.
  - accept && out_last && fifo_empty: word_valid<=0, beat_idx<=0 (HOLD→IDLE).
  - Otherwise: hold all state. out_data and out_last stay stable while out_valid && !out_ready.
- Latency:
  - First beat appears on out_valid 1 cycle after fifo_empty falls, with the block IDLE.
- Throughput:
  - 1 beat/cycle sustained while the FIFO is non-empty and out_ready=1.
  - 1 FIFO pop per 2^ratio_bits accepted beats.
- Width/wrap:
  - beat_idx wraps only via reload; it never increments past 2^ratio_bits-1.
  - With ratio_bits=0, every beat has out_last=1, and a pop is issued on each accept when the FIFO is not empty.
- Reset mid-word:
  - The held word is lost; the FIFO is not popped.
  - After reset release the block is IDLE, and the next FIFO head is loaded as soon as fifo_empty=0.

Test Plan:
- Reset, then FIFO holds 0xDDCCBBAA with out_ready=1 → beats AA,BB,CC,DD on 4 consecutive cycles, out_last only on DD, exactly one fifo_read_enable pulse.
- Two words 0x44332211, 0x88776655 preloaded, out_ready=1 → 8 consecutive beats 11..88 with no gap; the second pop coincides with acceptance of beat 44.
- out_ready low for 3 cycles while on beat BB → out_data holds BB, beat_idx is unchanged, no FIFO pop; resumes with CC.
- fifo_empty=1 throughout with out_ready=1 → out_valid=0 and fifo_read_enable=0 for all cycles; no read when empty.
- flush asserted while on beat BB, FIFO empty → next cycle out_valid=0; then push 0x0000EE01 → beats 01,EE,00,00.
- reset_n pulsed low asynchronously (mid-cycle) while on beat CC → out_valid=0 immediately; after release the next FIFO head is loaded from beat 0.
